// File: rtl/weight_loader_pkg.sv
// Shared encodings and sizes for the kernel weight loader and its bank.
// LAST_TAP is also what the filter decodes on weight_addr to leave INIT.
package weight_loader_pkg;

  localparam int NTAPS   = 9;
  localparam int WADDR_W = 4;
  localparam logic [WADDR_W-1:0] LAST_TAP = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic tap_in_range(input logic [WADDR_W-1:0] addr);
    return addr <= LAST_TAP;
  endfunction

endpackage

// File: rtl/weight_loader_bank.sv
// Double-buffered 2x9 coefficient file: host writes hit the shadow bank (~i_sel).
// Combinational read from bank i_rsel; same-edge write is forwarded when it targets the bank being read.
module weight_bank
  import weight_loader_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [WADDR_W-1:0]         i_waddr,
  input  logic signed [BITWIDTH-1:0] i_wdata,
  input  logic                       i_sel,
  input  logic                       i_rsel,
  input  logic [WADDR_W-1:0]         i_raddr,
  output logic signed [BITWIDTH-1:0] o_rdata
);

  logic [BITWIDTH-1:0] r_mem [2][NTAPS];
  logic                w_bypass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < NTAPS; t++) begin
          r_mem[b][t] <= '0;
        end
      end
    end else if (i_we && tap_in_range(i_waddr)) begin
      r_mem[~i_sel][i_waddr] <= i_wdata;
    end
  end

  // Only possible during a swap edge, when the shadow being written becomes the read bank.
  assign w_bypass = i_we && (i_waddr == i_raddr) && (i_rsel != i_sel);

  always_comb begin
    o_rdata = '0;
    if (tap_in_range(i_raddr)) begin
      o_rdata = w_bypass ? i_wdata : r_mem[i_rsel][i_raddr];
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streams the active 3x3 kernel to the filter on request; host commits swap banks at a safe point.
// First tap is registered the cycle after request is sampled; a commit mid-stream is deferred to DONE entry.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cfg_we,
  input  logic [WADDR_W-1:0]         i_cfg_addr,
  input  logic signed [BITWIDTH-1:0] i_cfg_wdata,
  input  logic                       i_cfg_commit,
  input  logic                       i_request,
  output logic signed [BITWIDTH-1:0] o_weight_out,
  output logic                       o_weight_valid,
  output logic [WADDR_W-1:0]         o_weight_addr,
  output logic                       o_interrupt,
  output logic                       o_busy,
  output logic                       o_commit_pending
);

  state_t                     r_state, w_state_nxt;
  logic [WADDR_W-1:0]         r_cnt, w_cnt_nxt;
  logic                       w_load, w_done_entry;
  logic                       w_swap, w_pending_nxt;
  logic                       r_sel, r_pending, r_valid, r_irq;
  logic [WADDR_W-1:0]         r_addr;
  logic signed [BITWIDTH-1:0] r_dout, w_rdata;

  weight_bank #(.BITWIDTH(BITWIDTH)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (i_cfg_we),
    .i_waddr (i_cfg_addr),
    .i_wdata (i_cfg_wdata),
    .i_sel   (r_sel),
    .i_rsel  (r_sel ^ w_swap),
    .i_raddr (r_cnt),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt is the next tap to present; it rests at 0 outside STREAM.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_done_entry = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (i_request) begin
          w_state_nxt = ST_STREAM;
          w_load      = 1'b1;
          w_cnt_nxt   = 4'd1;
        end
      end
      ST_STREAM: begin
        if (r_cnt == WADDR_W'(NTAPS)) begin
          w_state_nxt  = ST_DONE;
          w_done_entry = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_load    = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_DONE: begin
        if (!i_request) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_swap        = (i_cfg_commit || r_pending) && ((r_state != ST_STREAM) || w_done_entry);
    w_pending_nxt = (r_state == ST_STREAM) && !w_done_entry && (i_cfg_commit || r_pending);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel     <= 1'b0;
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      r_irq     <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
    end else begin
      r_sel     <= r_sel ^ w_swap;
      r_pending <= w_pending_nxt;
      r_irq     <= w_swap;
      r_valid   <= w_load;
      if (w_load) begin
        r_addr <= r_cnt;
        r_dout <= w_rdata;
      end
    end
  end

  assign o_weight_out     = r_dout;
  assign o_weight_valid   = r_valid;
  assign o_weight_addr    = r_addr;
  assign o_interrupt      = r_irq;
  assign o_busy           = (r_state == ST_STREAM);
  assign o_commit_pending = r_pending;

endmodule

// File: tb/tb_weight_loader.sv
// Randomized scoreboard bench for weight_loader: a two-bank array model predicts taps and interrupt cycles.
module tb_weight_loader;
  import weight_loader_pkg::*;

  localparam int BW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [WADDR_W-1:0]   cfg_addr = '0;
  logic signed [BW-1:0] cfg_wdata = '0;
  logic                 cfg_commit = 1'b0;
  logic                 request = 1'b0;
  logic signed [BW-1:0] weight_out;
  logic                 weight_valid;
  logic [WADDR_W-1:0]   weight_addr;
  logic                 interrupt;
  logic                 busy;
  logic                 commit_pending;

  weight_loader #(.BITWIDTH(BW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_cfg_we         (cfg_we),
    .i_cfg_addr       (cfg_addr),
    .i_cfg_wdata      (cfg_wdata),
    .i_cfg_commit     (cfg_commit),
    .i_request        (request),
    .o_weight_out     (weight_out),
    .o_weight_valid   (weight_valid),
    .o_weight_addr    (weight_addr),
    .o_interrupt      (interrupt),
    .o_busy           (busy),
    .o_commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Reference model: two banks of signed ints plus the active-bank index.
  int bank [2][NTAPS];
  int sel = 0;

  typedef struct {
    int addr;
    int data;
  } tap_t;
  tap_t tap_q[$];
  int   irq_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (weight_valid) begin
        if (tap_q.size() == 0) fail("unexpected_tap");
        else begin
          tap_t t;
          t = tap_q.pop_front();
          check("tap_addr", int'(weight_addr), t.addr);
          check("tap_data", int'(weight_out), t.data);
        end
      end
      if (interrupt) begin
        if (irq_q.size() == 0) fail("unexpected_irq");
        else check("irq_cycle", cyc, irq_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int a, input logic signed [BW-1:0] d);
    if (a < NTAPS) bank[1-sel][a] = int'(d);
  endtask

  task automatic write(input int a, input logic signed [BW-1:0] d);
    cfg_we = 1'b1; cfg_addr = WADDR_W'(a); cfg_wdata = d;
    model_write(a, d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit_now();
    cfg_commit = 1'b1;
    sel = 1 - sel;
    irq_q.push_back(cyc + 1);
    tick();
    cfg_commit = 1'b0;
    check("pending_idle_commit", int'(commit_pending), 0);
  endtask

  task automatic push_stream();
    for (int t = 0; t < NTAPS; t++) begin
      tap_t e;
      e.addr = t;
      e.data = bank[sel][t];
      tap_q.push_back(e);
    end
  endtask

  // One full request/stream/DONE/release cycle, with optional same-edge commit+write
  // at the request rise and an optional commit burst while streaming.
  task automatic run_stream(input bit st_commit, input bit st_wr, input int wr_a,
                            input logic signed [BW-1:0] wr_d, input bit mid_commit,
                            input int mid_off, input int mid_len, input int gap);
    int c;
    c = cyc;
    request = 1'b1;
    if (st_wr) begin
      cfg_we = 1'b1; cfg_addr = WADDR_W'(wr_a); cfg_wdata = wr_d;
      model_write(wr_a, wr_d);
    end
    if (st_commit) begin
      cfg_commit = 1'b1;
      sel = 1 - sel;
      irq_q.push_back(c + 1);
    end
    push_stream();
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    check("busy_stream", int'(busy), 1);
    for (int k = 1; k <= 8; k++) begin
      if (mid_commit && k >= mid_off && k < mid_off + mid_len) cfg_commit = 1'b1;
      if (mid_commit && k == mid_off) irq_q.push_back(c + 10);
      tick();
      cfg_commit = 1'b0;
      if (mid_commit && k == mid_off) check("pending_set", int'(commit_pending), 1);
    end
    tick();
    if (mid_commit) sel = 1 - sel;
    check("done_valid", int'(weight_valid), 0);
    check("done_addr", int'(weight_addr), 8);
    check("done_busy", int'(busy), 0);
    check("done_pending", int'(commit_pending), 0);
    tick();
    check("done_hold_addr", int'(weight_addr), 8);
    request = 1'b0;
    tick();
    check("idle_valid", int'(weight_valid), 0);
    check("idle_addr", int'(weight_addr), 8);
    repeat (gap) tick();
  endtask

  initial begin
    int c;
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < NTAPS; t++) bank[b][t] = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(weight_valid), 0);
    check("rst_addr", int'(weight_addr), 0);
    check("rst_out", int'(weight_out), 0);
    check("rst_irq", int'(interrupt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(commit_pending), 0);
    rst = 1'b1;
    tick();

    // Ramp kernel -4..4, committed from IDLE.
    for (int t = 0; t < NTAPS; t++) write(t, BW'(t - 4));
    commit_now();
    run_stream(0, 0, 0, 0, 0, 0, 0, 3);

    // Commit while streaming: the in-flight stream stays -4..4, repeated commits collapse.
    for (int t = 0; t < NTAPS; t++) write(t, 8'sd7);
    run_stream(0, 0, 0, 0, 1, 3, 2, 3);
    run_stream(0, 0, 0, 0, 0, 0, 0, 2);

    // Out-of-range writes are dropped: stream repeats, and shadow still holds the ramp.
    write(9, 8'sh55);
    write(15, 8'sh55);
    run_stream(0, 0, 0, 0, 0, 0, 0, 1);
    commit_now();
    run_stream(0, 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset at tap 4.
    c = cyc;
    request = 1'b1;
    push_stream();
    tick();
    repeat (4) tick();
    @(negedge clk);
    #2;
    rst = 1'b0;
    request = 1'b0;
    #1;
    check("arst_valid", int'(weight_valid), 0);
    check("arst_addr", int'(weight_addr), 0);
    check("arst_out", int'(weight_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_irq", int'(interrupt), 0);
    check("arst_pending", int'(commit_pending), 0);
    tap_q.delete();
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < NTAPS; t++) bank[b][t] = 0;
    sel = 0;
    tick();
    rst = 1'b1;
    tick();
    run_stream(0, 0, 0, 0, 0, 0, 0, 1);

    // Commit, request rise and tap-2 write on one edge.
    run_stream(1, 1, 2, -8'sd100, 0, 0, 0, 2);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      int nw, mode;
      nw = $urandom_range(0, 5);
      for (int w = 0; w < nw; w++) write($urandom_range(0, 15), BW'($urandom));
      mode = $urandom_range(0, 3);
      case (mode)
        1: begin
          commit_now();
          run_stream(0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 3));
        end
        2: run_stream(0, 0, 0, 0, 1, $urandom_range(1, 7), $urandom_range(1, 2),
                      $urandom_range(0, 3));
        3: run_stream(1, 1, $urandom_range(0, 15), BW'($urandom), 0, 0, 0,
                      $urandom_range(0, 3));
        default: run_stream(0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 3));
      endcase
    end

    repeat (5) tick();
    check("taps_drained", tap_q.size(), 0);
    check("irqs_drained", irq_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Upstream companion of the 3x3 2D filter PE. Holds the nine signed kernel coefficients in a double-buffered register bank written by the host/config side.
- Streams the active bank to the filter over the weight_in / weight_in_valid / weight_addr interface whenever the filter raises request.
- Host updates go to a shadow bank. A commit swaps the banks at a safe point and pulses interrupt so the filter re-enters INIT and refetches.

Parameters:
- BITWIDTH, 8, coefficient width (signed two's complement).
- NTAPS, 9, coefficients per kernel. Fixed 3x3; the address width of 4 bits covers it.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_we  in  1  host write strobe, shadow bank
- cfg_addr  in  4  host write tap index 0..8
- cfg_wdata  in  BITWIDTH  signed coefficient
- cfg_commit  in  1  request to swap shadow into active
- request  in  1  filter asks for coefficients (level)
- weight_out  out  BITWIDTH  signed coefficient to filter weight_in
- weight_valid  out  1  qualifies weight_out/weight_addr
- weight_addr  out  4  tap index for weight_out
- interrupt  out  1  one-cycle pulse: new kernel active, filter must refetch
- busy  out  1  high in STREAM
- commit_pending  out  1  commit accepted but swap deferred

Behaviour:
- Reset:
  - All outputs 0.
  - Both banks cleared to 0; active bank select = 0.
  - FSM = IDLE; pending flag = 0.
  - Reset mid-stream aborts immediately with no partial state retained.
- Storage: two banks of NTAPS x BITWIDTH registers; sel marks the active bank.
  - cfg_we with cfg_addr <= 8 writes the shadow bank (!sel) on the clock edge.
  - cfg_addr >= 9 is silently ignored.
  - Writes never touch the active bank.
- FSM states are IDLE, STREAM and DONE.
- IDLE:
  - request sampled high -> STREAM, and the cnt counter is cleared to 0.
  - weight_valid = 0; weight_addr holds its last value (0 after reset).
- STREAM:
  - Registered outputs: weight_valid = 1, weight_addr = cnt, weight_out = active[cnt].
  - One tap per cycle, addresses 0,1,...,8 on 9 consecutive cycles, first valid tap the cycle after request is sampled.
  - After addr 8 is presented -> DONE. request is not rechecked during STREAM.
- DONE:
  - weight_valid = 0.
  - weight_addr holds 8, because the filter FSM decodes weight_addr==8 combinationally to leave INIT.
  - request low -> IDLE; request still high -> stay in DONE.
- Commit:
  - cfg_commit in IDLE or DONE: sel toggles on that edge, and interrupt = 1 the following cycle for exactly one cycle.
  - cfg_commit in STREAM: pending = 1, commit_pending = 1. The swap occurs on the edge the FSM enters DONE, followed by the interrupt pulse. The stream in flight always completes from the old bank, so no mixed kernel is ever delivered.
  - Repeated commits while pending collapse into one swap.
  - cfg_commit together with cfg_we on the same edge: the write lands in the pre-swap shadow bank, which then becomes active.
- Simultaneous request rise and commit in IDLE: the swap wins, interrupt pulses, and the stream starts from the new bank.
- No arithmetic beyond the counter. Coefficients pass through unmodified, sign preserved.
- Estimated RTL size: ~180 lines.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_STREAM=2'd1, ST_DONE=2'd2
  - NTAPS=9
  - WADDR_W=4
  - LAST_TAP=8, also used by the filter's INIT exit decode
- One natural sub-module, weight_bank: a 2x9 register file with write port, bank select and combinational read. The FSM, counter and commit logic stay in weight_loader.

Test Plan:
- Reset, then write taps 0..8 = -4,-3,...,4 to shadow, commit -> interrupt pulses 1 cycle, commit_pending stays 0. Then raise request -> weight_valid high 9 cycles, addr 0..8, weight_out -4..4, weight_addr holds 8 in DONE.
- Write taps all = 7 and commit while streaming the -4..4 kernel -> stream completes with -4..4. commit_pending=1 until DONE entry, then interrupt. Next request streams all 7.
- cfg_we with cfg_addr=9, 15 and data 0x55 -> no bank change. A subsequent stream is identical to the prior one.
- Drop request in DONE -> IDLE, weight_valid 0. Raise it again 3 cycles later -> a fresh 9-tap stream starting at addr 0.
- Assert rst low at tap 4 of a stream -> all outputs 0 asynchronously. After release, FSM in IDLE and banks zero; a request streams nine zeros.
- Commit, request rise and a tap-2 write all on one edge in IDLE -> interrupt next cycle. The stream uses the new bank, including the tap-2 value just written.
